// File: rtl/refresh_scheduler_if.sv
// -----------------------------------------------------------------------------
// refresh_scheduler_if
//   Bundles the refresh handshake between the refresh scheduler and the
//   controller side (init FSM + command scheduler).
//
//   Signals:
//     init_done_i    controller -> scheduler  initialization-complete level
//     ref_ack_i      controller -> scheduler  refresh request accepted this cycle
//     ref_req_o      scheduler -> controller  refresh requested
//     ref_urgent_o   scheduler -> controller  pending count at postpone limit
//     ref_busy_o     scheduler -> controller  tRFC recovery window active
//     pending_cnt_o  scheduler -> controller  outstanding refresh count
//     ref_overflow_o scheduler -> controller  sticky: tick lost at limit
//
//   Modports:
//     master  controller side (drives init_done_i / ref_ack_i)
//     slave   refresh scheduler side
// -----------------------------------------------------------------------------
interface refresh_scheduler_if;
  logic       init_done_i;
  logic       ref_ack_i;
  logic       ref_req_o;
  logic       ref_urgent_o;
  logic       ref_busy_o;
  logic [3:0] pending_cnt_o;
  logic       ref_overflow_o;

  modport master (
    output init_done_i, ref_ack_i,
    input  ref_req_o, ref_urgent_o, ref_busy_o, pending_cnt_o, ref_overflow_o
  );

  modport slave (
    input  init_done_i, ref_ack_i,
    output ref_req_o, ref_urgent_o, ref_busy_o, pending_cnt_o, ref_overflow_o
  );
endinterface

// File: rtl/refresh_scheduler.sv
// -----------------------------------------------------------------------------
// refresh_scheduler
//   Generates periodic DRAM refresh requests every TREFI_CYCLES clocks, tracks
//   outstanding (postponed) refreshes, and holds off other traffic for
//   TRFC_CYCLES clocks after each accepted refresh.
//
//   Ports:
//     clk    single clock, all logic on posedge
//     rst_n  asynchronous active-low reset
//     bus    refresh_scheduler_if.slave (see interface file for signal list)
//
//   Parameters:
//     TREFI_CYCLES  refresh interval in clocks (2..65535)
//     TRFC_CYCLES   refresh recovery in clocks (1..1023)
//     MAX_POSTPONE  outstanding-refresh limit when postponement enabled (1..8)
//
//   Configuration macro:
//     REFRESH_POSTPONE_EN  defined   -> limit = MAX_POSTPONE
//                          undefined -> limit = 1 (no postponement)
// -----------------------------------------------------------------------------
module refresh_scheduler #(
  parameter int unsigned TREFI_CYCLES = 7800,
  parameter int unsigned TRFC_CYCLES  = 160,
  parameter int unsigned MAX_POSTPONE = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  refresh_scheduler_if.slave    bus
);

  typedef enum logic [1:0] {
    S_WAIT_INIT = 2'd0,
    S_RUN       = 2'd1,
    S_TRFC      = 2'd2
  } state_t;

  localparam logic [15:0] TREFI_LAST = 16'(TREFI_CYCLES - 1);
  localparam logic [9:0]  TRFC_LAST  = 10'(TRFC_CYCLES - 1);

`ifdef REFRESH_POSTPONE_EN
  localparam logic [3:0] LIMIT = 4'(MAX_POSTPONE);
`else
  localparam logic [3:0] LIMIT = 4'd1;
`endif

  // Elaboration-time range checks on the configuration.
  if (TREFI_CYCLES < 2 || TREFI_CYCLES > 65535) begin : g_bad_trefi
    $error("refresh_scheduler: TREFI_CYCLES out of range 2..65535");
  end
  if (TRFC_CYCLES < 1 || TRFC_CYCLES > 1023) begin : g_bad_trfc
    $error("refresh_scheduler: TRFC_CYCLES out of range 1..1023");
  end
  if (MAX_POSTPONE < 1 || MAX_POSTPONE > 8) begin : g_bad_postpone
    $error("refresh_scheduler: MAX_POSTPONE out of range 1..8");
  end

  state_t      state,    state_nxt;
  logic [15:0] intv_cnt, intv_nxt;
  logic [9:0]  rec_cnt,  rec_nxt;
  logic [3:0]  pending,  pend_nxt;
  logic        overflow, ovf_nxt;

  logic ref_req;
  logic tick;
  logic accept;

  // Request is a pure function of registers, so ref_ack_i never combinationally
  // reaches any output.
  assign ref_req = (state == S_RUN) && (pending != 4'd0);
  assign tick    = (state != S_WAIT_INIT) && (intv_cnt == TREFI_LAST);
  assign accept  = ref_req && bus.ref_ack_i;

  // NOTE: every variable gets its hold value before the case so no path leaves
  // it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_nxt = state;
    intv_nxt  = intv_cnt;
    rec_nxt   = rec_cnt;
    pend_nxt  = pending;
    ovf_nxt   = overflow;

    case (state)
      S_WAIT_INIT: begin
        if (bus.init_done_i) begin
          state_nxt = S_RUN;
          intv_nxt  = '0;
        end
      end

      default: begin
        if (!bus.init_done_i) begin
          // Init lost: start over, but keep the sticky error visible.
          state_nxt = S_WAIT_INIT;
          intv_nxt  = '0;
          rec_nxt   = '0;
          pend_nxt  = '0;
        end else begin
          intv_nxt = tick ? 16'd0 : intv_cnt + 16'd1;

          // A tick and an accept on the same edge cancel: the new refresh
          // replaces the one just issued, so the limit cannot be exceeded.
          if (tick && !accept) begin
            if (pending == LIMIT) ovf_nxt  = 1'b1;
            else                  pend_nxt = pending + 4'd1;
          end else if (accept && !tick) begin
            pend_nxt = pending - 4'd1;
          end

          if (state == S_RUN) begin
            if (accept) begin
              state_nxt = S_TRFC;
              rec_nxt   = '0;
            end
          end else if (rec_cnt == TRFC_LAST) begin
            // rec_cnt runs 0..TRFC_LAST, giving exactly TRFC_CYCLES busy cycles.
            state_nxt = S_RUN;
            rec_nxt   = '0;
          end else begin
            rec_nxt = rec_cnt + 10'd1;
          end
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_WAIT_INIT;
      intv_cnt <= '0;
      rec_cnt  <= '0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      intv_cnt <= intv_nxt;
      rec_cnt  <= rec_nxt;
      pending  <= pend_nxt;
      overflow <= ovf_nxt;
    end
  end

  assign bus.ref_req_o      = ref_req;
  assign bus.ref_urgent_o   = (pending == LIMIT);
  assign bus.ref_busy_o     = (state == S_TRFC);
  assign bus.pending_cnt_o  = pending;
  assign bus.ref_overflow_o = overflow;

endmodule

// File: tb/tb_refresh_scheduler.sv
// -----------------------------------------------------------------------------
// tb_refresh_scheduler
//   Directed self-checking bench for refresh_scheduler with TREFI_CYCLES=100,
//   TRFC_CYCLES=10, MAX_POSTPONE=8. Expected values follow the build-time
//   limit (8 with REFRESH_POSTPONE_EN, 1 without).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_refresh_scheduler;

`ifdef REFRESH_POSTPONE_EN
  localparam int LIMIT = 8;
`else
  localparam int LIMIT = 1;
`endif
  // Pending level used for the tick-plus-accept step.
  localparam int P = (LIMIT < 3) ? LIMIT : 3;

  logic clk = 1'b0;
  logic rst_n;

  refresh_scheduler_if bus ();

  refresh_scheduler #(
    .TREFI_CYCLES (100),
    .TRFC_CYCLES  (10),
    .MAX_POSTPONE (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  // Index of the last posedge passed since S_RUN entry (edge 0 = entry edge).
  int cur         = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to the negedge following posedge number 'target'.
  task automatic goto(input int target);
    repeat (target - cur) @(negedge clk);
    cur = target;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".req"},      8'(bus.ref_req_o),      8'd0);
    check({tag, ".urgent"},   8'(bus.ref_urgent_o),   8'd0);
    check({tag, ".busy"},     8'(bus.ref_busy_o),     8'd0);
    check({tag, ".pending"},  8'(bus.pending_cnt_o),  8'd0);
    check({tag, ".overflow"}, 8'(bus.ref_overflow_o), 8'd0);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.init_done_i = 1'b0;
    bus.ref_ack_i   = 1'b0;

    // ---- reset state -------------------------------------------------------
    #2;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("wait_init.req", 8'(bus.ref_req_o), 8'd0);

    // ---- first interval, no ack: request exactly 100 edges after entry ----
    bus.init_done_i = 1'b1;
    cur = -1;
    goto(99);
    check("e99.req", 8'(bus.ref_req_o), 8'd0);
    goto(100);
    check("e100.req",     8'(bus.ref_req_o),     8'd1);
    check("e100.pending", 8'(bus.pending_cnt_o), 8'd1);
    check("e100.urgent",  8'(bus.ref_urgent_o),  8'(LIMIT == 1));

    // ---- postponement up to the limit, then overflow ----------------------
    goto(199);
    check("e199.overflow", 8'(bus.ref_overflow_o), 8'd0);
    goto(200);
    check("e200.pending",  8'(bus.pending_cnt_o),  8'((LIMIT < 2) ? LIMIT : 2));
    check("e200.overflow", 8'(bus.ref_overflow_o), 8'(LIMIT == 1));
    check("e200.urgent",   8'(bus.ref_urgent_o),   8'(LIMIT <= 2));
    goto(799);
    check("e799.pending",  8'(bus.pending_cnt_o),  8'((LIMIT < 7) ? LIMIT : 7));
    check("e799.urgent",   8'(bus.ref_urgent_o),   8'(LIMIT <= 7));
    goto(800);
    check("e800.pending",  8'(bus.pending_cnt_o),  8'(LIMIT));
    check("e800.urgent",   8'(bus.ref_urgent_o),   8'd1);
    goto(899);
    check("e899.overflow", 8'(bus.ref_overflow_o), 8'(LIMIT == 1));
    goto(900);
    check("e900.overflow", 8'(bus.ref_overflow_o), 8'd1);
    check("e900.pending",  8'(bus.pending_cnt_o),  8'(LIMIT));
    check("e900.req",      8'(bus.ref_req_o),      8'd1);

    // ---- init_done drop: back to wait, overflow retained ------------------
    bus.init_done_i = 1'b0;
    goto(901);
    check("drop.req",      8'(bus.ref_req_o),      8'd0);
    check("drop.pending",  8'(bus.pending_cnt_o),  8'd0);
    check("drop.urgent",   8'(bus.ref_urgent_o),   8'd0);
    check("drop.overflow", 8'(bus.ref_overflow_o), 8'd1);

    // ---- asynchronous reset clears the sticky overflow --------------------
    #2 rst_n = 1'b0;
    #1 check("rst2.overflow", 8'(bus.ref_overflow_o), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- ack tied high: one-cycle accept, 10-cycle busy -------------------
    bus.ref_ack_i   = 1'b1;
    bus.init_done_i = 1'b1;
    cur = -1;
    goto(99);
    check("ack.e99.pending", 8'(bus.pending_cnt_o), 8'd0);
    goto(100);
    check("ack.e100.req",     8'(bus.ref_req_o),     8'd1);
    check("ack.e100.pending", 8'(bus.pending_cnt_o), 8'd1);
    check("ack.e100.busy",    8'(bus.ref_busy_o),    8'd0);
    goto(101);
    check("ack.e101.busy",    8'(bus.ref_busy_o),    8'd1);
    check("ack.e101.req",     8'(bus.ref_req_o),     8'd0);
    check("ack.e101.pending", 8'(bus.pending_cnt_o), 8'd0);
    goto(110);
    check("ack.e110.busy",    8'(bus.ref_busy_o),    8'd1);
    goto(111);
    check("ack.e111.busy",    8'(bus.ref_busy_o),    8'd0);
    check("ack.e111.req",     8'(bus.ref_req_o),     8'd0);
    goto(199);
    check("ack.e199.req",     8'(bus.ref_req_o),     8'd0);
    goto(200);
    check("ack.e200.req",     8'(bus.ref_req_o),     8'd1);
    check("ack.e200.pending", 8'(bus.pending_cnt_o), 8'd1);
    goto(201);
    check("ack.e201.busy",    8'(bus.ref_busy_o),    8'd1);
    bus.ref_ack_i = 1'b0;

    // ---- tick and accept on the same edge ---------------------------------
    goto(200 + 100 * P);
    check("same.pre.pending", 8'(bus.pending_cnt_o), 8'(P));
    goto(299 + 100 * P);
    bus.ref_ack_i = 1'b1;
    goto(300 + 100 * P);
    bus.ref_ack_i = 1'b0;
    check("same.pending",  8'(bus.pending_cnt_o),  8'(P));
    check("same.busy",     8'(bus.ref_busy_o),     8'd1);
    check("same.req",      8'(bus.ref_req_o),      8'd0);
    check("same.overflow", 8'(bus.ref_overflow_o), 8'd0);

    // ---- ack while busy is ignored; one more accept after recovery --------
    goto(305 + 100 * P);
    bus.ref_ack_i = 1'b1;
    goto(306 + 100 * P);
    check("busyack.pending", 8'(bus.pending_cnt_o), 8'(P));
    bus.ref_ack_i = 1'b0;
    goto(320 + 100 * P);
    check("rec.req", 8'(bus.ref_req_o), 8'd1);
    bus.ref_ack_i = 1'b1;
    goto(321 + 100 * P);
    bus.ref_ack_i = 1'b0;
    check("acc2.busy",    8'(bus.ref_busy_o),    8'd1);
    check("acc2.pending", 8'(bus.pending_cnt_o), 8'(P - 1));

    // ---- async reset mid-recovery, then a fresh interval ------------------
    goto(325 + 100 * P);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst3");
    bus.init_done_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst3.wait.req",  8'(bus.ref_req_o),  8'd0);
    check("rst3.wait.busy", 8'(bus.ref_busy_o), 8'd0);
    bus.init_done_i = 1'b1;
    cur = -1;
    goto(99);
    check("rst3.e99.req",  8'(bus.ref_req_o),     8'd0);
    goto(100);
    check("rst3.e100.req", 8'(bus.ref_req_o),     8'd1);
    check("rst3.e100.pending", 8'(bus.pending_cnt_o), 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
